// File: rtl/cmd_link_pkg.sv
// rtl/cmd_link_pkg.sv - shared constants and UART state type for the command link responder
// Holds the command marker, the UART FSM state enum, detector bit positions
// and command-byte field positions used by the RX sub-module and the top.
package cmd_link_pkg;

    // Upper two bits a command byte must carry when marker checking is enabled.
    localparam logic [1:0] CMD_MARKER = 2'b10;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_t;

    // detector_in bit positions
    localparam int DET_FRONT = 0;
    localparam int DET_LEFT  = 1;
    localparam int DET_RIGHT = 2;
    localparam int DET_BACK  = 3;

    // command byte field positions
    localparam int CMD_MOVE_LSB = 0;
    localparam int CMD_MOVE_MSB = 3;
    localparam int CMD_PLACE    = 4;
    localparam int CMD_DESTROY  = 5;
    localparam int CMD_MARK_LSB = 6;
    localparam int CMD_MARK_MSB = 7;

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - UART 8N1 byte receiver with input synchronizer
// Ports:
//   sys_clk, rst    : clock, synchronous active-high reset
//   rx              : asynchronous serial input (idle high)
//   byte_data[7:0]  : last received byte, valid while byte_valid is high
//   byte_valid      : high in the cycle the stop bit is sampled high
//   stop_err        : high in the cycle the stop bit is sampled low
module uart_rx_byte
    import cmd_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       stop_err
);

    localparam int               CNT_W     = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             rx_meta, rx_sync, rx_prev;
    uart_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             hold_q, hold_d;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
            state_q <= UART_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            hold_q  <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        bit_d      = bit_q;
        shift_d    = shift_q;
        hold_d     = hold_q;
        byte_valid = 1'b0;
        stop_err   = 1'b0;
        case (state_q)
            UART_IDLE: begin
                cnt_d = '0;
                if (rx_prev && !rx_sync) state_d = UART_START;
            end
            UART_START: begin
                // Half-bit check filters glitches shorter than half a bit.
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_sync ? UART_IDLE : UART_DATA;
                end
            end
            UART_DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = UART_STOP;
                end
            end
            UART_STOP: begin
                if (hold_q) begin
                    // After a framing error, wait for the line to return high
                    // so a low line is not mistaken for a new start bit.
                    cnt_d = '0;
                    if (rx_sync) begin
                        hold_d  = 1'b0;
                        state_d = UART_IDLE;
                    end
                end else if (cnt_q == FULL_LAST) begin
                    cnt_d = '0;
                    if (rx_sync) begin
                        byte_valid = 1'b1;
                        state_d    = UART_IDLE;
                    end else begin
                        stop_err = 1'b1;
                        hold_d   = 1'b1;
                    end
                end
            end
            default: state_d = UART_IDLE;
        endcase
    end

    assign byte_data = shift_q;

endmodule

// File: rtl/cmd_link_responder.sv
// rtl/cmd_link_responder.sv - UART command receiver, status transmitter and link watchdog
// Optional feature macro: CMD_LINK_MARKER_CHECK_EN (accept only bytes with [7:6]==2'b10).
// Ports:
//   sys_clk, rst           : clock, synchronous active-high reset
//   rx / tx                : UART 8N1 command input / status output
//   detector_in[3:0]       : front, left, right, back detectors
//   moving_state[3:0]      : last accepted command bits [3:0]
//   place_barrier          : last accepted command bit 4
//   destroy_barrier        : last accepted command bit 5
//   cmd_valid              : one-cycle pulse per accepted command
//   frame_err              : one-cycle pulse on bad stop bit or rejected byte
//   link_alive             : high while the command watchdog has not expired
module cmd_link_responder
    import cmd_link_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 10417,
    parameter int STATUS_PERIOD = 1_000_000,
    parameter int LINK_TIMEOUT  = 50_000_000
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    input  logic [3:0] detector_in,
    output logic [3:0] moving_state,
    output logic       place_barrier,
    output logic       destroy_barrier,
    output logic       cmd_valid,
    output logic       frame_err,
    output logic       link_alive
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] TX_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam int               PER_W    = $clog2(STATUS_PERIOD + 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(STATUS_PERIOD - 1);
    localparam int               WD_W     = $clog2(LINK_TIMEOUT + 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(LINK_TIMEOUT - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(LINK_TIMEOUT);

    logic [7:0] rx_byte;
    logic       rx_valid, rx_stop_err, byte_ok, accept;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .rx         (rx),
        .byte_data  (rx_byte),
        .byte_valid (rx_valid),
        .stop_err   (rx_stop_err)
    );

`ifdef CMD_LINK_MARKER_CHECK_EN
    assign byte_ok = (rx_byte[CMD_MARK_MSB:CMD_MARK_LSB] == CMD_MARKER);
`else
    logic unused_marker;
    assign unused_marker = ^rx_byte[CMD_MARK_MSB:CMD_MARK_LSB];
    assign byte_ok       = 1'b1;
`endif

    assign accept = rx_valid && byte_ok;

    // Command registers and watchdog. The counter parks at LINK_TIMEOUT so
    // expiry clears the outputs once; an accepted command always wins.
    logic [WD_W-1:0] wd_cnt;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            moving_state    <= '0;
            place_barrier   <= 1'b0;
            destroy_barrier <= 1'b0;
            cmd_valid       <= 1'b0;
            frame_err       <= 1'b0;
            link_alive      <= 1'b0;
            wd_cnt          <= '0;
        end else begin
            cmd_valid <= accept;
            frame_err <= rx_stop_err || (rx_valid && !byte_ok);
            if (accept) begin
                moving_state    <= rx_byte[CMD_MOVE_MSB:CMD_MOVE_LSB];
                place_barrier   <= rx_byte[CMD_PLACE];
                destroy_barrier <= rx_byte[CMD_DESTROY];
                link_alive      <= 1'b1;
                wd_cnt          <= '0;
            end else if (wd_cnt != WD_LIMIT) begin
                wd_cnt <= wd_cnt + 1'b1;
                if (wd_cnt == WD_LAST) begin
                    link_alive      <= 1'b0;
                    moving_state    <= '0;
                    place_barrier   <= 1'b0;
                    destroy_barrier <= 1'b0;
                end
            end
        end
    end

    // Status transmitter
    uart_state_t      tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             pending_q, pending_d;
    logic [3:0]       last_nibble_q, last_nibble_d;
    logic [PER_W-1:0] period_q, period_d;
    logic             tx_d, bit_done, trigger;

    assign bit_done = (tx_cnt_q == TX_LAST);
    assign trigger  = (detector_in != last_nibble_q) || (period_q == PER_LAST);

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            tx_state_q    <= UART_IDLE;
            tx_cnt_q      <= '0;
            tx_bit_q      <= '0;
            tx_shift_q    <= '0;
            pending_q     <= 1'b0;
            last_nibble_q <= '0;
            period_q      <= '0;
            tx            <= 1'b1;
        end else begin
            tx_state_q    <= tx_state_d;
            tx_cnt_q      <= tx_cnt_d;
            tx_bit_q      <= tx_bit_d;
            tx_shift_q    <= tx_shift_d;
            pending_q     <= pending_d;
            last_nibble_q <= last_nibble_d;
            period_q      <= period_d;
            tx            <= tx_d;
        end
    end

    always_comb begin
        tx_state_d    = tx_state_q;
        tx_cnt_d      = tx_cnt_q + 1'b1;
        tx_bit_d      = tx_bit_q;
        tx_shift_d    = tx_shift_q;
        pending_d     = pending_q;
        last_nibble_d = last_nibble_q;
        period_d      = (period_q == PER_LAST) ? period_q : period_q + 1'b1;
        tx_d          = 1'b1;
        case (tx_state_q)
            UART_IDLE: tx_cnt_d = '0;
            UART_START: begin
                if (bit_done) begin
                    tx_state_d = UART_DATA;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                end
            end
            UART_DATA: begin
                if (bit_done) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_state_d = UART_STOP;
                end
            end
            UART_STOP: begin
                if (bit_done) begin
                    tx_state_d = UART_IDLE;
                    tx_cnt_d   = '0;
                end
            end
            default: tx_state_d = UART_IDLE;
        endcase
        // A frame launches from idle or straight off the last stop cycle, so a
        // queued frame follows with exactly one stop bit of spacing.
        if ((tx_state_q == UART_IDLE || (tx_state_q == UART_STOP && bit_done))
                && (trigger || pending_q)) begin
            tx_state_d    = UART_START;
            tx_cnt_d      = '0;
            tx_shift_d    = {4'b0000, detector_in};
            last_nibble_d = detector_in;
            period_d      = '0;
            pending_d     = 1'b0;
        end else if (trigger && tx_state_q != UART_IDLE) begin
            pending_d = 1'b1;
        end
        case (tx_state_d)
            UART_START: tx_d = 1'b0;
            UART_DATA:  tx_d = tx_shift_d[0];
            default:    tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_cmd_link_responder.sv
// tb/tb_cmd_link_responder.sv - scoreboard bench for cmd_link_responder
module tb_cmd_link_responder;

    localparam int CPB = 16;
    localparam int SP  = 2000;
    localparam int LT  = 5000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       tx;
    logic [3:0] det = 4'h0;
    logic [3:0] moving_state;
    logic       place_barrier, destroy_barrier, cmd_valid, frame_err, link_alive;
    logic [5:0] fields;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_cmd_cyc = 0;
    bit tx_ignore = 1'b0;

    typedef struct {
        logic [7:0] data;
        int         lo;
        int         hi;
    } tx_exp_t;

    logic [5:0] exp_cmd[$];
    int         exp_err[$];
    tx_exp_t    exp_tx[$];

    cmd_link_responder #(
        .CLKS_PER_BIT  (CPB),
        .STATUS_PERIOD (SP),
        .LINK_TIMEOUT  (LT)
    ) dut (
        .sys_clk         (clk),
        .rst             (rst),
        .rx              (rx),
        .tx              (tx),
        .detector_in     (det),
        .moving_state    (moving_state),
        .place_barrier   (place_barrier),
        .destroy_barrier (destroy_barrier),
        .cmd_valid       (cmd_valid),
        .frame_err       (frame_err),
        .link_alive      (link_alive)
    );

    assign fields = {destroy_barrier, place_barrier, moving_state};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_tx(input logic [7:0] d, input int lo, input int hi);
        tx_exp_t e;
        e.data = d;
        e.lo   = lo;
        e.hi   = hi;
        exp_tx.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop_ok;
        tick(CPB);
        if (!stop_ok) tick(2 * CPB);
        rx = 1'b1;
        tick(2 * CPB);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx  = 1'b1;
        det = 4'h0;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("rst_tx", int'(tx), 1);
        check("rst_fields", int'(fields), 0);
        check("rst_cmd_valid", int'(cmd_valid), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_link_alive", int'(link_alive), 0);
    endtask

    task automatic drain();
        check("cmd_queue_left", exp_cmd.size(), 0);
        check("err_queue_left", exp_err.size(), 0);
        check("tx_queue_left", exp_tx.size(), 0);
        exp_cmd.delete();
        exp_err.delete();
        exp_tx.delete();
    endtask

    // Command / framing-error monitor
    always @(negedge clk) begin
        if (!rst && cmd_valid) begin
            last_cmd_cyc = cyc;
            check("cmd_expected", int'(exp_cmd.size() > 0), 1);
            if (exp_cmd.size() > 0) check("cmd_fields", int'(fields), int'(exp_cmd.pop_front()));
        end
        if (!rst && frame_err) begin
            check("frame_err_expected", int'(exp_err.size() > 0), 1);
            if (exp_err.size() > 0) void'(exp_err.pop_front());
        end
    end

    // Status-line monitor: decodes each frame at bit centres
    initial begin : tx_mon
        int         t0;
        logic [7:0] b;
        logic       start_bit, stop_bit;
        bit         aborted;
        tx_exp_t    e;
        forever begin
            @(negedge clk);
            if (!rst && !tx_ignore && tx == 1'b0) begin
                t0 = cyc;
                b = '0;
                start_bit = 1'b1;
                stop_bit = 1'b0;
                aborted = 1'b0;
                for (int k = 1; k <= 9 * CPB + CPB / 2; k++) begin
                    @(negedge clk);
                    if (rst || tx_ignore) aborted = 1'b1;
                    if (k == CPB / 2) start_bit = tx;
                    if (k >= CPB + CPB / 2 && k <= 8 * CPB + CPB / 2 && ((k - CPB / 2) % CPB) == 0)
                        b[(k - CPB - CPB / 2) / CPB] = tx;
                    if (k == 9 * CPB + CPB / 2) stop_bit = tx;
                end
                if (!aborted) begin
                    check("tx_start_bit", int'(start_bit), 0);
                    check("tx_stop_bit", int'(stop_bit), 1);
                    check("tx_expected", int'(exp_tx.size() > 0), 1);
                    if (exp_tx.size() > 0) begin
                        e = exp_tx.pop_front();
                        check("tx_byte", int'(b), int'(e.data));
                        total++;
                        if (t0 < e.lo || t0 > e.hi) begin
                            bad++;
                            $display("FAIL tx_start_cycle: got %0d want %0d..%0d", t0, e.lo, e.hi);
                        end
                    end
                end
            end
        end
    end

    initial begin : stim
        int c;
        int n;

        // Command reception
        do_reset();
        exp_cmd.push_back(6'h25);
        send_byte(8'hA5, 1'b1);
        check("a5_moving", int'(moving_state), 5);
        check("a5_place", int'(place_barrier), 0);
        check("a5_destroy", int'(destroy_barrier), 1);
        check("a5_alive", int'(link_alive), 1);
`ifdef CMD_LINK_MARKER_CHECK_EN
        exp_err.push_back(1);
        send_byte(8'h45, 1'b1);
        check("45_rejected_fields", int'(fields), 6'h25);
`else
        exp_cmd.push_back(6'h05);
        send_byte(8'h45, 1'b1);
        check("45_accepted_fields", int'(fields), 6'h05);
`endif
        exp_cmd.push_back(6'h1A);
        send_byte(8'h9A, 1'b1);
        check("9a_fields", int'(fields), 6'h1A);
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(3 * CPB);
        check("glitch_fields", int'(fields), 6'h1A);
        exp_err.push_back(1);
        send_byte(8'h81, 1'b0);
        check("stop_err_fields", int'(fields), 6'h1A);
        exp_cmd.push_back(6'h03);
        send_byte(8'h83, 1'b1);
        check("after_err_fields", int'(fields), 6'h03);
        drain();

        // Change-triggered and periodic status frames
        do_reset();
        tick(5);
        c = cyc;
        det = 4'b0011;
        expect_tx(8'h03, c + 1, c + 2);
        expect_tx(8'h03, c + 1 + SP, c + 1 + SP);
        expect_tx(8'h03, c + 1 + 2 * SP, c + 1 + 2 * SP);
        tick(2 * SP + 200);
        drain();

        // Two changes during one frame coalesce into one follow-up frame
        do_reset();
        tick(5);
        c = cyc;
        det = 4'b0001;
        expect_tx(8'h01, c + 1, c + 2);
        expect_tx(8'h06, c + 1 + 10 * CPB, c + 1 + 10 * CPB);
        tick(40);
        det = 4'b0010;
        tick(40);
        det = 4'b0110;
        tick(400);
        drain();

        // Watchdog expiry, relink, reset during a frame
        do_reset();
        tx_ignore = 1'b1;
        exp_cmd.push_back(6'h0F);
        send_byte(8'h8F, 1'b1);
        check("8f_moving", int'(moving_state), 15);
        check("8f_alive", int'(link_alive), 1);
        while (cyc < last_cmd_cyc + LT - 1) tick(1);
        check("wd_alive_before", int'(link_alive), 1);
        tick(1);
        check("wd_alive_after", int'(link_alive), 0);
        check("wd_moving_cleared", int'(moving_state), 0);
        exp_cmd.push_back(6'h1A);
        send_byte(8'h9A, 1'b1);
        check("relink_alive", int'(link_alive), 1);
        check("relink_fields", int'(fields), 6'h1A);
        n = 0;
        while (tx != 1'b0 && n < 2 * SP + 200) begin
            tick(1);
            n++;
        end
        check("tx_frame_seen", int'(tx), 0);
        rst = 1'b1;
        tick(1);
        check("rst_mid_tx_tx", int'(tx), 1);
        check("rst_mid_tx_alive", int'(link_alive), 0);
        tick(2);
        rst = 1'b0;
        tick(2);
        tx_ignore = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cmd_link_responder.md
CMD_LINK_RESPONDER -- requirements
Module: cmd_link_responder

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10417, sys_clk cycles per UART bit (100 MHz / 9600 baud).
REQ-002 SHALL have parameter STATUS_PERIOD, default 1_000_000, cycles between unforced status transmissions.
REQ-003 SHALL have parameter LINK_TIMEOUT, default 50_000_000, cycles without an accepted command before fail-safe.
REQ-004 SHALL have port sys_clk  in  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port rx  in  1  UART 8N1 command line (asynchronous).
REQ-007 SHALL have port tx  out  1  UART 8N1 status line.
REQ-008 SHALL have port detector_in  in  4  bit0 front, bit1 left, bit2 right, bit3 back.
REQ-009 SHALL have port moving_state  out  4  last accepted command bits [3:0].
REQ-010 SHALL have port place_barrier  out  1  last accepted command bit 4.
REQ-011 SHALL have port destroy_barrier  out  1  last accepted command bit 5.
REQ-012 SHALL have port cmd_valid  out  1  one-cycle pulse per accepted command.
REQ-013 SHALL have port frame_err  out  1  one-cycle pulse on a bad stop bit or rejected byte.
REQ-014 SHALL have port link_alive  out  1  high while the watchdog has not expired.

Function
REQ-015 rx SHALL pass through a 2-flop synchronizer before use.
REQ-016 RX FSM SHALL use states IDLE, START, DATA, STOP; IDLE->START on a synchronized falling edge.
REQ-017 START SHALL sample at CLKS_PER_BIT/2; a high sample returns to IDLE with no output (glitch).
REQ-018 DATA SHALL sample 8 bits LSB-first, one every CLKS_PER_BIT cycles, at bit centres.
REQ-019 STOP sampled low SHALL pulse frame_err, discard the byte, and hold in STOP until rx is high.
REQ-020 A byte with [7:6]==2'b10 SHALL update moving_state, place_barrier and destroy_barrier and pulse cmd_valid one cycle after the stop sample.
REQ-021 Any other byte SHALL be discarded with a frame_err pulse; outputs unchanged.
REQ-022 Status byte SHALL be {4'b0000, detector_in}, captured in the cycle the transmission starts.
REQ-023 TX SHALL trigger when detector_in differs from the last transmitted nibble or the period counter reaches STATUS_PERIOD-1.
REQ-024 TX FSM SHALL use states IDLE, START, DATA, STOP; each bit lasts CLKS_PER_BIT cycles; tx high in IDLE and STOP.
REQ-025 A trigger while TX is busy SHALL set one pending flag; the next frame starts the cycle after STOP ends; further triggers coalesce.
REQ-026 The period counter SHALL reload to 0 whenever a frame starts.
REQ-027 The watchdog counter SHALL reload on every cmd_valid; on reaching LINK_TIMEOUT, link_alive SHALL drop and moving_state, place_barrier and destroy_barrier SHALL clear to 0.
REQ-028 If cmd_valid and watchdog expiry coincide, the command SHALL win and link_alive SHALL stay high.
REQ-029 link_alive SHALL rise again with the next cmd_valid.

Reset
REQ-030 On rst: tx=1; moving_state=0; place_barrier=0; destroy_barrier=0; cmd_valid=0; frame_err=0; link_alive=0; both FSMs IDLE; all counters and the pending flag 0; last-transmitted nibble 0.
REQ-031 rst during a frame SHALL abandon it; tx SHALL be 1 after the next edge.

Configuration
REQ-032 With CMD_LINK_MARKER_CHECK_EN defined, REQ-020/021 apply; without it, every well-framed byte SHALL be accepted and bits [7:6] ignored.

Structure
REQ-033 Package cmd_link_pkg SHALL hold: marker constant 2'b10; the UART state enum; detector bit indices; command field indices.
REQ-034 The RX path SHALL be sub-module uart_rx_byte (synchronizer, RX FSM, byte + valid + stop_err outputs); TX and watchdog SHALL stay in the top.

Verification (CLKS_PER_BIT=16, STATUS_PERIOD=2000, LINK_TIMEOUT=5000)
REQ-035 Send 0xA5 -> moving_state=4'h5, place_barrier=0, destroy_barrier=1, one cmd_valid pulse, link_alive=1.
REQ-036 Send 0x45 with the marker check on -> frame_err pulse, outputs unchanged; with the check off -> moving_state=4'h5.
REQ-037 Send 0x81 with stop bit low -> frame_err pulse, no cmd_valid, RX resumes after rx goes high.
REQ-038 Change detector_in 0->4'b0011 -> tx frame 0x03 within 1 cycle of idle; hold it steady -> repeat frame every 2000 cycles.
REQ-039 Change detector_in twice during one frame -> exactly one follow-up frame carrying the latest value.
REQ-040 Send 0x8F, then idle 5000 cycles -> link_alive=0, moving_state=0; assert rst mid-TX -> tx=1 next cycle.
